serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//   Bit-serial adder. Loads two WIDTH-bit operands, feeds them LSB-first into
//   one full_adder, and keeps the carry in a flip-flop between bits. Gives a
//   WIDTH-bit sum + carry out after WIDTH cycles. It is the sequential stage
//   that drives the 1-bit full adder. It is the area-minimal alternative to
//   the ripple/carry-select adders.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits, legal range 1..32
// PORTS
//   clk    in   1      single clock, all state on rising edge
//   rst_n  in   1      asynchronous reset, active-low
//   start  in   1      request: capture A, B, Cin and begin addition
//   A      in   WIDTH  operand A, sampled only when start is accepted
//   B      in   WIDTH  operand B, sampled only when start is accepted
//   Cin    in   1      carry-in to bit 0, sampled with A/B
//   busy   out  1      addition in progress
//   done   out  1      one-cycle pulse: sum/Cout valid this cycle and after
//   sum    out  WIDTH  registered result, held until the next completion
//   Cout   out  1      registered carry out of bit WIDTH-1
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE; busy=0, done=0, sum=0, Cout=0.
//     Shift regs, carry FF and bit counter are cleared.
//   - FSM states: IDLE -> SHIFT -> DONE.
//     IDLE:  start=1 -> load A/B shift regs, carry<=Cin, cnt<=0, go SHIFT.
//     SHIFT: each cycle, full_adder(carry, a_sr[0], b_sr[0]) is evaluated.
//            The sum bit shifts into res_sr MSB. carry<=fa_Cout.
//            a_sr/b_sr shift right. cnt++.
//            On cnt==WIDTH-1: sum<=final res, Cout<=fa_Cout, go DONE.
//     DONE:  done=1 for exactly this cycle.
//            If start=1 -> reload and go SHIFT (back-to-back).
//            Otherwise go IDLE.
//   - busy=1 exactly in SHIFT: WIDTH cycles.
//   - Latency: start sampled at edge N. busy is high in cycles N+1..N+WIDTH.
//     done is high in the cycle after edge N+WIDTH.
//     Throughput is one add per WIDTH+1 cycles.
//   - start while busy=1: ignored. Operands are not resampled.
//   - sum/Cout change only on the completing edge. They hold while busy.
//   - Reset asserted mid-SHIFT: operation is aborted and all outputs go to
//     their reset values. No done pulse is produced.
//   - WIDTH=1: SHIFT lasts one cycle. cnt is at least 1 bit wide.
//   - Arithmetic: {Cout,sum} = A + B + Cin, unsigned, modulo 2^(WIDTH+1).
// CONFIGURATION
//   Macro SERIAL_ADDER_OVF_EN.
//   Defined: extra output port ovf (out, 1).
//     ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (signed
//     two's-complement overflow).
//     ovf is registered with sum, reset 0, and held like sum.
//   Undefined: no ovf port and no extra flop. The rest of the behaviour is
//   identical.
// STRUCTURE
//   - Shared include arith_defs.vh:
//       localparam state codes S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2
//       CNT_W = (WIDTH>1) ? $clog2(WIDTH) : 1
//   - One sub-module: full_adder (existing 1-bit cell), instantiated once.
//   - No other hierarchy.
// TESTING (WIDTH=8 unless noted)
//   1. A=8'h0F, B=8'h01, Cin=0, start 1 cycle ->
//      busy 8 cycles; done at edge 9; sum=8'h10, Cout=0.
//   2. A=8'hFF, B=8'h01, Cin=0 -> sum=8'h00, Cout=1, ovf=0.
//      Then A=8'h7F, B=8'h01 -> sum=8'h80, Cout=0, ovf=1 (OVF_EN build).
//   3. start with A=8'h55, B=8'h55. Pulse start again at cycle 3 with
//      A=8'hFF -> ignored; result sum=8'hAA, Cout=0.
//   4. start during the done cycle, A=8'h80, B=8'h80, Cin=1 ->
//      next done is 9 cycles later; sum=8'h01, Cout=1.
//   5. rst_n low at cycle 4 of SHIFT ->
//      busy/done/sum/Cout=0 immediately (async); no done pulse;
//      the next start works normally.
//   6. WIDTH=1: A=1, B=1, Cin=1 -> done 2 edges after start; sum=1, Cout=1.
//   Plus a random sweep of 10k ops versus a reference model of A+B+Cin.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and bit-counter sizing shared by the bit-serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: 1-bit full adder cell driven one bit per cycle by the serial adder
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, WIDTH cycles per add; SERIAL_ADDER_OVF_EN adds a signed-overflow output
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CNT_W = cnt_width(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nx;
  logic [CNT_W-1:0] cnt;
  logic carry, fa_s, fa_cout, load, last;
  full_adder u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .s(fa_s), .cout(fa_cout));
  assign load = start && (state != S_SHIFT);
  assign last = (state == S_SHIFT) && (cnt == CNT_W'(WIDTH - 1));
  assign res_nx = WIDTH'({fa_s, res_sr} >> 1);
  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  // accept start outside SHIFT, leave SHIFT after the top bit, DONE lasts one cycle
  always_comb begin
    state_nx = S_IDLE;
    state_nx = load ? S_SHIFT : (state == S_SHIFT) ? (last ? S_DONE : S_SHIFT) : S_IDLE;
  end
  // operand shifters, inter-bit carry and bit counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      res_sr <= '0;
      carry <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      a_sr <= A;
      b_sr <= B;
      carry <= Cin;
      cnt <= '0;
    end else if (busy) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      res_sr <= res_nx;
      carry <= fa_cout;
      cnt <= cnt + CNT_W'(1);
    end
  // visible result changes only on the completing edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum <= '0;
      Cout <= 1'b0;
    end else if (last) begin
      sum <= res_nx;
      Cout <= fa_cout;
    end
`ifdef SERIAL_ADDER_OVF_EN
  // signed overflow: carry into the top bit differs from carry out of it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (last) ovf <= carry ^ fa_cout;
`endif
endmodule
